// File: rtl/video_timing_tpg.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_tpg
// Brief    : Raster timing generator (vs/hs/de) with selectable test patterns.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_tpg #(
    parameter int   H_DISP   = 1280,
    parameter int   H_FRONT  = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BACK   = 220,
    parameter int   V_DISP   = 720,
    parameter int   V_FRONT  = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BACK   = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   R_W      = 5,
    parameter int   G_W      = 6,
    parameter int   B_W      = 5,
    parameter int   CHK_LOG2 = 4,
    localparam int  DW       = R_W + G_W + B_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [2:0]    mode_i,
    input  logic [DW-1:0] solid_i,
    output logic          vs_o,
    output logic          hs_o,
    output logic          de_o,
    output logic [DW-1:0] data_o,
    output logic          sof_o,
    output logic [7:0]    frame_cnt_o
);

    localparam logic [11:0] c_H_TOTAL  = 12'(H_DISP + H_FRONT + H_SYNC + H_BACK);
    localparam logic [11:0] c_V_TOTAL  = 12'(V_DISP + V_FRONT + V_SYNC + V_BACK);
    localparam logic [11:0] c_H_DISP   = 12'(H_DISP);
    localparam logic [11:0] c_V_DISP   = 12'(V_DISP);
    localparam logic [11:0] c_HS_START = 12'(H_DISP + H_FRONT);
    localparam logic [11:0] c_HS_END   = 12'(H_DISP + H_FRONT + H_SYNC);
    localparam logic [11:0] c_VS_START = 12'(V_DISP + V_FRONT);
    localparam logic [11:0] c_VS_END   = 12'(V_DISP + V_FRONT + V_SYNC);
    localparam logic [11:0] c_BAR_W    = 12'((H_DISP / 8 > 0) ? H_DISP / 8 : 1);

    localparam logic [2:0] c_MODE_SOLID   = 3'd0;
    localparam logic [2:0] c_MODE_BARS    = 3'd1;
    localparam logic [2:0] c_MODE_RAMP    = 3'd2;
    localparam logic [2:0] c_MODE_CHECKER = 3'd3;
    localparam logic [2:0] c_MODE_MOVBAR  = 3'd4;

    logic [11:0]   r_h_cnt;
    logic [11:0]   r_v_cnt;
    logic [7:0]    r_frame_cnt;
    logic [11:0]   r_bar_px;
    logic [2:0]    r_bar;
    logic [2:0]    r_mode;
    logic [DW-1:0] r_solid;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_start;
    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic [2:0]    w_mode;
    logic [DW-1:0] w_solid;
    logic [11:0]   w_mb;
    logic          w_chk;
    logic [DW-1:0] w_pix;

    assign w_h_last      = (r_h_cnt == c_H_TOTAL - 12'd1);
    assign w_v_last      = (r_v_cnt == c_V_TOTAL - 12'd1);
    assign w_frame_start = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_active      = (r_h_cnt < c_H_DISP) && (r_v_cnt < c_V_DISP);
    assign w_hs          = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    assign w_vs          = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

    // New mode/colour apply from the first pixel of a frame, so bypass the latch there.
    assign w_mode  = w_frame_start ? mode_i  : r_mode;
    assign w_solid = w_frame_start ? solid_i : r_solid;

    assign w_mb  = r_h_cnt - {2'b00, r_frame_cnt, 2'b00};
    assign w_chk = r_h_cnt[CHK_LOG2] ^ r_v_cnt[CHK_LOG2];

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 8'd0;
        end else if (en_i && w_h_last && w_v_last) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    // Bar index tracks h_cnt incrementally, avoiding a divider by BAR_W.
    always_ff @(posedge clk) begin
        if (rst || !en_i || w_h_last) begin
            r_bar_px <= 12'd0;
            r_bar    <= 3'd0;
        end else if (r_bar_px == c_BAR_W - 12'd1) begin
            r_bar_px <= 12'd0;
            r_bar    <= (r_bar == 3'd7) ? 3'd7 : r_bar + 3'd1;
        end else begin
            r_bar_px <= r_bar_px + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= c_MODE_SOLID;
            r_solid <= '0;
        end else begin
            r_mode  <= w_mode;
            r_solid <= w_solid;
        end
    end

    always_comb begin
        w_pix = w_solid;
        case (w_mode)
            c_MODE_BARS:    w_pix = {{R_W{~r_bar[1]}}, {G_W{~r_bar[2]}}, {B_W{~r_bar[0]}}};
            c_MODE_RAMP:    w_pix = {r_h_cnt[R_W-1:0], r_h_cnt[G_W-1:0], r_h_cnt[B_W-1:0]};
            c_MODE_CHECKER: w_pix = w_chk ? '1 : '0;
            c_MODE_MOVBAR:  w_pix = (w_mb < 12'd16) ? '1 : '0;
            default:        w_pix = w_solid;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            vs_o   <= ~VS_POL;
            hs_o   <= ~HS_POL;
            de_o   <= 1'b0;
            data_o <= '0;
            sof_o  <= 1'b0;
        end else begin
            vs_o   <= w_vs ? VS_POL : ~VS_POL;
            hs_o   <= w_hs ? HS_POL : ~HS_POL;
            de_o   <= w_active;
            data_o <= w_active ? w_pix : '0;
            sof_o  <= w_frame_start;
        end
    end

    // Registered copy lines the counter up with the sof_o of the frame it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_o <= 8'd0;
        end else begin
            frame_cnt_o <= r_frame_cnt;
        end
    end

endmodule
`default_nettype wire
